// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    localparam int          MDU_ITER = 32;
    localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shifted;

    assign w_shifted = {i_rem, i_bit};
    assign o_qbit    = (w_shifted >= {1'b0, i_divisor});
    // When the divisor fits, the true difference is below the divisor, so
    // the modular WIDTH-bit subtraction is exact.
    assign o_rem     = o_qbit ? (w_shifted[WIDTH-1:0] - i_divisor) : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO registers in 33 cycles.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU complete as no-ops.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = MDU_ITER
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER);

    mdu_state_e         r_state, w_state_next;
    logic [CW-1:0]      r_count, w_count_next;
    logic [2*WIDTH-1:0] r_acc, w_acc_next;
    logic [WIDTH-1:0]   r_b_mag, w_b_mag_next;
    logic               r_neg, w_neg_next;
    logic [WIDTH-1:0]   r_hi, w_hi_next;
    logic [WIDTH-1:0]   r_lo, w_lo_next;
    logic               r_done, w_done_next;

    logic               w_signed_op, w_sign_a, w_sign_b;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc, w_prod;

    assign w_signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign w_sign_a    = w_signed_op & operandA[WIDTH-1];
    assign w_sign_b    = w_signed_op & operandB[WIDTH-1];
    assign w_mag_a     = w_sign_a ? (-operandA) : operandA;
    assign w_mag_b     = w_sign_b ? (-operandB) : operandB;

    // Accumulator holds {partial product, remaining multiplier bits}.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b_mag} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod    = r_neg ? (-r_acc) : r_acc;

`ifdef MDU_DIV_EN
    logic               r_is_div, w_is_div_next;
    logic               r_neg_r, w_neg_r_next;
    logic               r_div0, w_div0_next;
    logic [WIDTH-1:0]   r_a_raw, w_a_raw_next;
    logic [WIDTH-1:0]   w_div_rem, w_quot, w_rem;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_acc;

    // For division the accumulator holds {remainder, dividend/quotient}.
    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_bit     (r_acc[WIDTH-1]),
        .i_divisor (r_b_mag),
        .o_rem     (w_div_rem),
        .o_qbit    (w_qbit)
    );

    assign w_div_acc = {w_div_rem, r_acc[WIDTH-2:0], w_qbit};
    assign w_quot    = r_neg ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem     = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_acc_next   = r_acc;
        w_b_mag_next = r_b_mag;
        w_neg_next   = r_neg;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_done_next  = 1'b0;
`ifdef MDU_DIV_EN
        w_is_div_next = r_is_div;
        w_neg_r_next  = r_neg_r;
        w_div0_next   = r_div0;
        w_a_raw_next  = r_a_raw;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_acc_next   = {{WIDTH{1'b0}}, w_mag_a};
                    w_b_mag_next = w_mag_b;
                    w_neg_next   = w_sign_a ^ w_sign_b;
                    w_count_next = '0;
`ifdef MDU_DIV_EN
                    w_is_div_next = op[1];
                    w_neg_r_next  = w_sign_a;
                    w_div0_next   = (operandB == '0);
                    w_a_raw_next  = operandA;
                    w_state_next  = S_RUN;
`else
                    if (op[1]) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = S_RUN;
                    end
`endif
                end else begin
                    if (hiWrite) w_hi_next = writeData;
                    if (loWrite) w_lo_next = writeData;
                end
            end
            S_RUN: begin
`ifdef MDU_DIV_EN
                w_acc_next = r_is_div ? w_div_acc : w_mul_acc;
`else
                w_acc_next = w_mul_acc;
`endif
                w_count_next = r_count + 1'b1;
                if (r_count == CW'(ITER - 1)) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_hi_next = w_prod[2*WIDTH-1:WIDTH];
                w_lo_next = w_prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
                if (r_is_div) begin
                    if (r_div0) begin
                        w_hi_next = r_a_raw;
                        w_lo_next = WIDTH'(DIV0_LO);
                    end else begin
                        w_hi_next = w_rem;
                        w_lo_next = w_quot;
                    end
                end
`endif
                w_done_next  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_b_mag <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
`ifdef MDU_DIV_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_a_raw  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_acc   <= w_acc_next;
            r_b_mag <= w_b_mag_next;
            r_neg   <= w_neg_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_done  <= w_done_next;
`ifdef MDU_DIV_EN
            r_is_div <= w_is_div_next;
            r_neg_r  <= w_neg_r_next;
            r_div0   <= w_div0_next;
            r_a_raw  <= w_a_raw_next;
`endif
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
